data_mem_ctrl: RTL
==================

// Module: data_mem_ctrl
// PURPOSE
//   Parametrised single-port data memory with a valid/ready request channel and a registered
//   response channel. Supports RV32 load/store sizes LB/LH/LW/LBU/LHU/SB/SH/SW with byte-lane
//   steering and sign/zero extension. Flags misaligned, out-of-range and illegal-size accesses.
//   Sits between the pipeline MEM stage and data RAM.
// PARAMETERS
//   DATA_WIDTH  32            word width in bits; fixed at 32 for RV32
//   ADDR_WIDTH  32            byte-address width
//   DEPTH       1024          number of words in the RAM
//   BASE_ADDR   32'h02000000  byte address of word 0
//   ERR_CNT_W   8             width of the saturating error counter
// PORTS
//   clk         in   1           clock, rising edge
//   rst_n       in   1           asynchronous reset, active-low
//   req_valid   in   1           request present
//   req_ready   out  1           request accepted when req_valid && req_ready
//   req_we      in   1           1 = store, 0 = load
//   req_addr    in   ADDR_WIDTH  byte address
//   req_size    in   2           00 = byte, 01 = half, 10 = word, 11 = illegal
//   req_unsigned in  1           loads: 1 = zero-extend, 0 = sign-extend
//   req_wdata   in   DATA_WIDTH  store data; LSBs hold the byte or half
//   rsp_valid   out  1           response present
//   rsp_ready   in   1           response consumed when rsp_valid && rsp_ready
//   rsp_rdata   out  DATA_WIDTH  load result, extended; 0 for stores and errors
//   rsp_err     out  1           access faulted
//   err_count   out  ERR_CNT_W   saturating count of faulted requests
// BEHAVIOUR
//   Reset
//     - rsp_valid=0, rsp_rdata=0, rsp_err=0, err_count=0.
//     - RAM contents are not reset.
//     - A request in flight when reset asserts is dropped.
//   Request channel
//     - req_ready = !rsp_valid || rsp_ready (one-entry response register).
//     - Accept at edge N: rsp_valid=1 from N+1 with rdata/err. Fixed latency of 1 cycle.
//     - rsp_valid holds, and rsp_rdata/rsp_err stay stable, until rsp_ready is sampled high.
//     - Back-to-back accept with rsp_ready=1 gives a response every cycle.
//     - No accept: rsp_valid clears on the handshake edge.
//   Address decode
//     - off = req_addr - BASE_ADDR; word index idx = off[ADDR_WIDTH-1:2]; lane = req_addr[1:0].
//   Error, checked in this priority:
//     - size==11;
//     - misaligned: half with lane[0]=1, or word with lane!=0;
//     - req_addr < BASE_ADDR, or idx >= DEPTH.
//     - On error: no RAM write, rsp_rdata=0, rsp_err=1, err_count += 1, saturating at all-ones.
//   Store (on accept, no error)
//     - RAM[idx] written at accept edge N.
//     - Byte: lane (lane) <= wdata[7:0].
//     - Half: lanes lane, lane+1 <= wdata[15:0].
//     - Word: all 4 lanes.
//     - Other lanes unchanged. Response: rdata=0, err=0.
//   Load (on accept, no error)
//     - RAM[idx] read at accept; selected byte or half shifted down by lane*8.
//     - Bit 7 or 15 replicated if req_unsigned=0, else zeros.
//     - Word returned as-is.
//   Ordering
//     - A load accepted at N+1 after a store accepted at N to the same word returns the new data.
//     - Single port: only one access per cycle; no bypass is needed.
// TESTING
//   - Reset: rst_n=0 mid-stream -> rsp_valid=0, err_count=0 immediately (asynchronous).
//   - SW 0x02000010 <= 0xDEADBEEF, then LW 0x02000010 -> rsp_rdata=0xDEADBEEF, err=0, one cycle
//     after accept.
//   - SB 0x02000011 <= 0x80, then LB -> 0xFFFFFF80; LBU -> 0x00000080.
//     LW -> 0xDEAD80EF (other bytes preserved).
//   - LH 0x02000013 -> err=1, rdata=0, err_count=1.
//     LW 0x01FFFFFC -> err=1. LW BASE+4*DEPTH -> err=1. size=11 -> err=1.
//     No RAM change after any faulted store.
//   - Backpressure: rsp_ready=0 for 3 cycles -> req_ready=0; rsp_valid and rsp_rdata held stable.
//     Then release -> next request accepted the same cycle.
//   - Throughput: 8 back-to-back requests with rsp_ready=1 -> 8 responses on consecutive cycles.
//     Drive 300 faulted requests -> err_count saturates at 255.

Source files
------------

// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle between the MEM stage and the data memory controller.
// The master issues requests and consumes responses; the slave is the memory.
interface data_mem_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ERR_CNT_W  = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic [ERR_CNT_W-1:0]  err_count;

  modport master (
    output req_valid, req_we, req_addr,
    output req_size, req_unsigned, req_wdata,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata,
    input  rsp_err, err_count
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_size, req_unsigned, req_wdata,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_rdata,
    output rsp_err, err_count
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Single-port RV32 data memory with byte-lane steering, load extension,
// fault detection and a one-entry registered response.
module data_mem_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h0200_0000,
  parameter int ERR_CNT_W  = 8
) (
  input logic clk,
  input logic rst_n,
  data_mem_ctrl_if.slave bus
);

  localparam int IW = $clog2(DEPTH);
  localparam int XW = ADDR_WIDTH - 2;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_d;
  logic                  rsp_err_q;
  logic [ERR_CNT_W-1:0]  err_cnt_q;

  logic                  accept;
  logic [ADDR_WIDTH-1:0] off;
  logic [XW-1:0]         idx;
  logic [IW-1:0]         idx_w;
  logic [1:0]            lane;
  logic                  is_b, is_h, is_w;
  logic                  fault;
  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] wlanes;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] ld_val;
  logic                  unused_off;

  assign bus.req_ready = !rsp_valid_q || bus.rsp_ready;
  assign accept = bus.req_valid && bus.req_ready;

  assign off        = bus.req_addr - BASE_ADDR;
  assign idx        = off[ADDR_WIDTH-1:2];
  assign idx_w      = idx[IW-1:0];
  assign lane       = bus.req_addr[1:0];
  assign unused_off = ^off[1:0];

  assign is_b = bus.req_size == 2'b00;
  assign is_h = bus.req_size == 2'b01;
  assign is_w = bus.req_size == 2'b10;

  // Size, alignment and range faults all collapse to one flag.
  assign fault = (bus.req_size == 2'b11)
              || (is_h && lane[0])
              || (is_w && (lane != 2'b00))
              || (bus.req_addr < BASE_ADDR)
              || (idx >= XW'(DEPTH));

  always_comb begin
    be     = 4'b0000;
    wlanes = bus.req_wdata;
    unique case (1'b1)
      is_b: begin
        be     = 4'b0001 << lane;
        wlanes = {4{bus.req_wdata[7:0]}};
      end
      is_h: begin
        be     = 4'b0011 << lane;
        wlanes = {2{bus.req_wdata[15:0]}};
      end
      is_w: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept && bus.req_we && !fault) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx_w][b*8 +: 8] <= wlanes[b*8 +: 8];
      end
    end
  end

  assign rd_word = mem_q[idx_w];
  assign shifted = rd_word >> {lane, 3'b000};

  always_comb begin
    ld_val = shifted;
    unique case (1'b1)
      is_b: ld_val = bus.req_unsigned
                   ? {24'h0, shifted[7:0]}
                   : {{24{shifted[7]}}, shifted[7:0]};
      is_h: ld_val = bus.req_unsigned
                   ? {16'h0, shifted[15:0]}
                   : {{16{shifted[15]}}, shifted[15:0]};
      default: ld_val = shifted;
    endcase
  end

  assign rsp_rdata_d = (fault || bus.req_we) ? '0 : ld_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= fault;
      if (fault && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 1'b1;
    end else if (bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.err_count = err_cnt_q;

endmodule
